// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
//  - occ_e       : stage occupancy (EMPTY / ONE / FULL)
//  - DEF_*       : default payload / counter widths
//  - CTRL_IDLE_B : bit value replicated to form the idle control word
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 32;

    // Idle control payload is all zeros so a bubble never asserts RegWrite/MemWrite.
    localparam logic CTRL_IDLE_B = 1'b0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held transaction: valid bit + control payload + data payload.
// Ports:
//  clock, reset   rising-edge clock, synchronous active-high reset (clears everything)
//  clr_i          drop the entry: valid and ctrl cleared, data left as is
//  ld_i           capture valid_i / ctrl_i / data_i (clr_i wins)
//  valid_o, ctrl_o, data_o   registered entry contents; ctrl_o is idle when valid_o=0
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              ld_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{CTRL_IDLE_B}};
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= {CTRL_W{CTRL_IDLE_B}};
        end else if (ld_i) begin
            valid_q <= valid_i;
            // Control is only ever stored alongside a live entry.
            ctrl_q  <= valid_i ? ctrl_i : {CTRL_W{CTRL_IDLE_B}};
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous flush. Full throughput under backpressure; in_ready is a register,
// so there is no combinational path from out_ready to in_ready.
// Ports:
//  clock, reset           rising-edge clock, synchronous active-high reset
//  flush                  kill all held entries (reset has priority)
//  in_valid/in_ready      upstream handshake, in_ctrl/in_data payload
//  out_valid/out_ready    downstream handshake, out_ctrl/out_data payload
//  stall_count            cycles with out_valid && !out_ready, saturating
// Optional feature: define PIPE_STALL_CNT_EN to add the CNT_W parameter,
// the stall_count port and its counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W
`ifdef PIPE_STALL_CNT_EN
   ,parameter int CNT_W  = DEF_CNT_W
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
   ,output logic [CNT_W-1:0]  stall_count
`endif
);

    occ_e state_q, state_d;
    logic in_ready_q;

    logic              main_vld, skid_vld;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    logic main_ld, main_clr, main_from_skid, skid_ld, skid_clr;
    logic accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = main_vld && out_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            // Anything accepted this cycle is dropped along with the held entries.
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: if (accept) begin
                    main_ld = 1'b1;
                    state_d = OCC_ONE;
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        // Main is stalled and must not change: park input in skid.
                        skid_ld = 1'b1;
                        state_d = OCC_FULL;
                    end else if (drain) begin
                        main_clr = 1'b1;
                        state_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: if (drain) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                    state_d        = OCC_ONE;
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                    state_d  = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            // Registered copy of "not FULL" for the next cycle.
            in_ready_q <= (state_d != OCC_FULL);
        end
    end

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .valid_i (main_from_skid ? skid_vld  : 1'b1),
        .ctrl_i  (main_from_skid ? skid_ctrl : in_ctrl),
        .data_i  (main_from_skid ? skid_data : in_data),
        .valid_o (main_vld),
        .ctrl_o  (main_ctrl),
        .data_o  (main_data)
    );

    pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .valid_i (1'b1),
        .ctrl_i  (in_ctrl),
        .data_i  (in_data),
        .valid_o (skid_vld),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_ctrl  = main_vld ? main_ctrl : {CTRL_W{CTRL_IDLE_B}};
    assign out_data  = main_data;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Flush does not clear the counter; only reset does.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (main_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 8;
`ifdef PIPE_STALL_CNT_EN
    localparam int NW = 4;
    localparam int STALL_MAX = (1 << NW) - 1;
    logic [NW-1:0] stall_count;
`endif

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;

    always #5 clock = ~clock;

    pipe_stage_skid #(
        .DATA_W(DW),
        .CTRL_W(CW)
`ifdef PIPE_STALL_CNT_EN
       ,.CNT_W(NW)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
       ,.stall_count (stall_count)
`endif
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } item_t;

    // Reference model: the stage is a FIFO of capacity 2 whose head is the output.
    item_t       q[$];
    bit          m_ready     = 1'b1;
    bit          m_after_rst = 1'b0;
    int unsigned m_stall     = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic item_t mk(input int c, input int d);
        item_t it;
        it.c = c[CW-1:0];
        it.d = d[DW-1:0];
        return it;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, check outputs 1 time unit later.
    task automatic step(input bit rst, input bit fl, input bit iv, input item_t it, input bit ordy);
        bit            pre_valid, acc;
        logic [CW-1:0] ec;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = it.c;
        in_data   = it.d;
        out_ready = ordy;
        pre_valid = (q.size() > 0);
        acc       = iv && m_ready;
        @(posedge clock);
`ifdef PIPE_STALL_CNT_EN
        if (rst) m_stall = 0;
        else if (pre_valid && !ordy && m_stall < STALL_MAX) m_stall++;
`endif
        if (rst) begin
            q.delete();
            m_after_rst = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pre_valid && ordy) void'(q.pop_front());
            if (acc) begin
                q.push_back(it);
                m_after_rst = 1'b0;
            end
        end
        m_ready = (q.size() < 2);
        #1;
        ec = (q.size() > 0) ? q[0].c : '0;
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("out_ctrl", 64'(out_ctrl), 64'(ec));
        if (q.size() > 0) chk("out_data", 64'(out_data), 64'(q[0].d));
        else if (m_after_rst) chk("out_data_rst", 64'(out_data), 64'd0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    endtask

    initial begin
        item_t cur;
        bit    iv, ordy, fl, stuck;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        // Reset held 2 cycles while upstream offers data.
        step(1, 0, 1, mk(8'h55, 32'hDEAD), 1);
        step(1, 0, 1, mk(8'h55, 32'hDEAD), 1);
        step(0, 0, 0, mk(0, 0), 1);

        // Streaming: back-to-back, no gaps.
        for (int i = 0; i < 20; i++) step(0, 0, 1, mk(i + 1, 32'h100 + i), 1);
        step(0, 0, 0, mk(0, 0), 1);
        step(0, 0, 0, mk(0, 0), 1);

        // Backpressure: two items fill the stage, third waits then follows in order.
        step(0, 0, 1, mk(8'hA1, 32'h1111), 0);
        step(0, 0, 1, mk(8'hA2, 32'h2222), 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, mk(8'hA3, 32'h3333), 0);
        chk("hold_item1", 64'(out_data), 64'h1111);
        step(0, 0, 1, mk(8'hA3, 32'h3333), 1);
        step(0, 0, 1, mk(8'hA3, 32'h3333), 1);
        step(0, 0, 0, mk(0, 0), 1);
        step(0, 0, 0, mk(0, 0), 1);

        // Flush while FULL with a new item offered.
        step(0, 0, 1, mk(8'hB1, 32'h4444), 0);
        step(0, 0, 1, mk(8'hB2, 32'h5555), 0);
        step(0, 1, 1, mk(8'hB3, 32'h6666), 0);
        chk("flush_ctrl", 64'(out_ctrl), 64'd0);
        step(0, 0, 0, mk(0, 0), 1);
        step(0, 0, 0, mk(0, 0), 1);

        // Random traffic with occasional flush; upstream holds payload while stalled.
        cur = mk(0, 0);
        stuck = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!stuck) cur = mk(int'($urandom), int'($urandom));
            iv   = stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            stuck = iv && !m_ready && !fl;
            step(0, fl, iv, cur, ordy);
        end

        // Long stall then flush; counter (when present) saturates and survives flush.
        step(0, 1, 0, mk(0, 0), 1);
        step(0, 0, 1, mk(8'hC1, 32'h7777), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, mk(0, 0), 0);
        step(0, 1, 0, mk(0, 0), 0);
`ifdef PIPE_STALL_CNT_EN
        chk("stall_sat", 64'(stall_count), 64'd15);
`endif

        // Reset mid-transfer discards everything.
        step(0, 0, 1, mk(8'hD1, 32'h8888), 0);
        step(0, 0, 1, mk(8'hD2, 32'h9999), 0);
        step(1, 0, 1, mk(8'hD3, 32'hAAAA), 0);
        step(0, 0, 0, mk(0, 0), 1);
        step(0, 0, 1, mk(8'hE1, 32'hBBBB), 1);
        step(0, 0, 0, mk(0, 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
